// File: rtl/uart_rx_axis_fifo.sv
// uart_rx_axis_fifo: oversampled UART receiver with majority-vote bit recovery,
// break/frame/parity/overrun flagging, and a show-ahead FIFO drained over AXI-Stream.
module uart_rx_axis_fifo #(
    parameter int unsigned BIT_PER_WORD  = 8,
    parameter int unsigned PARITY_BIT    = 0,
    parameter int unsigned STOP_BITS_NUM = 1,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DIV_W         = 16,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic                            RX,
    output logic [BIT_PER_WORD-1:0]         tdata,
    output logic [3:0]                      tuser,
    output logic                            tvalid,
    input  logic                            tready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overrun
);

    localparam int unsigned PW   = $clog2(OVERSAMPLE);
    localparam int unsigned HALF = OVERSAMPLE / 2;
    localparam int unsigned BW   = $clog2(BIT_PER_WORD);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW   = BIT_PER_WORD + 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_s;

    // Two-flop synchroniser; both stages reset to the idle level.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] div_eff;
    logic             tick;

    // Live divisor while idle; frozen copy while a frame is being received.
    assign div_eff = (state == IDLE) ? baud_div : div_q;
    assign tick    = (tick_cnt >= div_eff);

    // Free-running divider counter, wraps on every tick.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [PW-1:0]           lowcnt,   lowcnt_nxt;
    logic [PW-1:0]           phase,    phase_nxt;
    logic                    samp_ok,  samp_ok_nxt;
    logic                    s_early,  s_early_nxt;
    logic                    s_mid,    s_mid_nxt;
    logic [BW-1:0]           bitcnt,   bitcnt_nxt;
    logic [BIT_PER_WORD-1:0] shreg,    shreg_nxt;
    logic                    par_bit,  par_nxt;
    logic                    ferr,     ferr_nxt;
    logic                    all_zero, zero_nxt;

    logic                    in_frame;
    logic [PW-1:0]           phase_inc;
    logic                    bit_val;
    logic                    resolve;
    logic                    par_x;
    logic                    perr;
    logic                    push;
    logic [2:0]              push_flags;

    assign in_frame  = (state == DATA) || (state == PARITY) || (state == STOP1) || (state == STOP2);
    assign phase_inc = (phase == PW'(OVERSAMPLE - 1)) ? '0 : phase + PW'(1);
    // Majority of the samples one tick before, at, and one tick after the bit centre.
    assign bit_val   = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
    assign resolve   = tick && in_frame && samp_ok && (phase_inc == PW'(1));
    assign par_x     = (^shreg) ^ par_bit;
    assign perr      = (PARITY_BIT == 1) ? ~par_x : ((PARITY_BIT == 2) ? par_x : 1'b0);

    // State and datapath registers of the receiver.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            div_q    <= '0;
            lowcnt   <= '0;
            phase    <= '0;
            samp_ok  <= 1'b0;
            s_early  <= 1'b1;
            s_mid    <= 1'b1;
            bitcnt   <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_q    <= div_nxt;
            lowcnt   <= lowcnt_nxt;
            phase    <= phase_nxt;
            samp_ok  <= samp_ok_nxt;
            s_early  <= s_early_nxt;
            s_mid    <= s_mid_nxt;
            bitcnt   <= bitcnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_nxt;
            ferr     <= ferr_nxt;
            all_zero <= zero_nxt;
        end
    end

    // Next-state, sampling and word-completion logic.
    always_comb begin
        state_nxt   = state;
        div_nxt     = div_q;
        lowcnt_nxt  = lowcnt;
        phase_nxt   = phase;
        samp_ok_nxt = samp_ok;
        s_early_nxt = s_early;
        s_mid_nxt   = s_mid;
        bitcnt_nxt  = bitcnt;
        shreg_nxt   = shreg;
        par_nxt     = par_bit;
        ferr_nxt    = ferr;
        zero_nxt    = all_zero;
        push        = 1'b0;
        push_flags  = 3'b000;

        if (tick && in_frame) begin
            phase_nxt = phase_inc;
            if (phase_inc == PW'(OVERSAMPLE - 1)) begin
                s_early_nxt = rx_s;
                samp_ok_nxt = 1'b1;
            end
            if (phase_inc == '0) begin
                s_mid_nxt = rx_s;
            end
        end

        case (state)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_nxt  = START;
                    lowcnt_nxt = PW'(1);
                    div_nxt    = baud_div;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        lowcnt_nxt = lowcnt + PW'(1);
                        if (lowcnt == PW'(HALF - 1)) begin
                            state_nxt   = DATA;
                            phase_nxt   = '0;
                            samp_ok_nxt = 1'b0;
                            bitcnt_nxt  = '0;
                            par_nxt     = 1'b0;
                            ferr_nxt    = 1'b0;
                            zero_nxt    = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (resolve) begin
                    samp_ok_nxt = 1'b0;
                    shreg_nxt   = {bit_val, shreg[BIT_PER_WORD-1:1]};
                    zero_nxt    = all_zero & ~bit_val;
                    if (bitcnt == BW'(BIT_PER_WORD - 1)) begin
                        bitcnt_nxt = '0;
                        state_nxt  = (PARITY_BIT != 0) ? PARITY : STOP1;
                    end else begin
                        bitcnt_nxt = bitcnt + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (resolve) begin
                    samp_ok_nxt = 1'b0;
                    par_nxt     = bit_val;
                    zero_nxt    = all_zero & ~bit_val;
                    state_nxt   = STOP1;
                end
            end
            STOP1: begin
                if (resolve) begin
                    samp_ok_nxt = 1'b0;
                    if (STOP_BITS_NUM == 2) begin
                        ferr_nxt  = ~bit_val;
                        zero_nxt  = all_zero & ~bit_val;
                        state_nxt = STOP2;
                    end else begin
                        push       = 1'b1;
                        push_flags = {all_zero & ~bit_val, ~bit_val, perr};
                        state_nxt  = bit_val ? IDLE : WAIT_HIGH;
                    end
                end
            end
            STOP2: begin
                if (resolve) begin
                    samp_ok_nxt = 1'b0;
                    push        = 1'b1;
                    push_flags  = {all_zero & ~bit_val, ferr | ~bit_val, perr};
                    state_nxt   = (ferr | ~bit_val) ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (tick && rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO with overrun tracking
    // ------------------------------------------------------------------
    logic [EW-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          sticky;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [EW-1:0] head;

    assign full   = (fifo_count == CW'(FIFO_DEPTH));
    assign tvalid = (fifo_count != '0);
    assign pop    = tvalid && tready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign head   = mem[rptr];
    assign tdata  = tvalid ? head[BIT_PER_WORD-1:0] : '0;
    assign tuser  = tvalid ? head[EW-1:BIT_PER_WORD] : 4'b0000;

    // Storage array; the sticky drop flag rides along on the next accepted word.
    always_ff @(posedge aclk) begin
        if (aresetn && accept) begin
            mem[wptr] <= {sticky, push_flags, shreg};
        end
    end

    // Pointers, occupancy, sticky drop flag and overrun pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            sticky     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= drop;
            if (accept) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (accept) begin
                sticky <= 1'b0;
            end else if (drop) begin
                sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Self-checking bench for uart_rx_axis_fifo: an 8N1 instance and an 8E1 instance
// driven by a bit-level serial sender, checked through expected/observed beat queues.
module tb_uart_rx_axis_fifo;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] baud_div;
    logic        rx, rx_p;
    logic        tready, tready_p;
    logic [7:0]  tdata, tdata_p;
    logic [3:0]  tuser, tuser_p;
    logic        tvalid, tvalid_p;
    logic [4:0]  fifo_count, fifo_count_p;
    logic        overrun, overrun_p;

    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] exp_p_q[$];
    logic [11:0] obs_p_q[$];

    int checks  = 0;
    int passed  = 0;
    int ovr_cnt = 0;

    always #5 aclk = ~aclk;

    uart_rx_axis_fifo dut (
        .aclk(aclk), .aresetn(aresetn), .baud_div(baud_div), .RX(rx),
        .tdata(tdata), .tuser(tuser), .tvalid(tvalid), .tready(tready),
        .fifo_count(fifo_count), .overrun(overrun)
    );

    uart_rx_axis_fifo #(.PARITY_BIT(2)) dut_p (
        .aclk(aclk), .aresetn(aresetn), .baud_div(baud_div), .RX(rx_p),
        .tdata(tdata_p), .tuser(tuser_p), .tvalid(tvalid_p), .tready(tready_p),
        .fifo_count(fifo_count_p), .overrun(overrun_p)
    );

    // Record every completed handshake and every overrun pulse.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (tvalid && tready)     obs_q.push_back({tuser, tdata});
            if (tvalid_p && tready_p) obs_p_q.push_back({tuser_p, tdata_p});
            if (overrun)              ovr_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic int bitc();
        return (int'(baud_div) + 1) * 16;
    endfunction

    task automatic tick_wait(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic set_line(input bit p, input logic v);
        if (p) rx_p = v;
        else   rx   = v;
    endtask

    // Serial frame: start, 8 data LSB first, optional parity, one stop, one idle bit.
    task automatic send_frame(input bit p, input logic [7:0] d, input bit has_par,
                              input logic par_v, input logic stop_v, input int glitch_bit);
        int bc;
        int t;
        bc = bitc();
        t  = int'(baud_div) + 1;
        set_line(p, 1'b0);
        tick_wait(bc);
        for (int i = 0; i < 8; i++) begin
            set_line(p, d[i]);
            if (i == glitch_bit) begin
                tick_wait(bc / 2 - t / 2);
                set_line(p, ~d[i]);
                tick_wait(t);
                set_line(p, d[i]);
                tick_wait(bc - (bc / 2 - t / 2) - t);
            end else begin
                tick_wait(bc);
            end
        end
        if (has_par) begin
            set_line(p, par_v);
            tick_wait(bc);
        end
        set_line(p, stop_v);
        tick_wait(bc);
        set_line(p, 1'b1);
        tick_wait(bc);
    endtask

    task automatic wait_obs(input bit p, input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if ((p ? obs_p_q.size() : obs_q.size()) >= n) break;
            @(posedge aclk);
        end
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; rx = 1'b1; rx_p = 1'b1;
        tready = 1'b1; tready_p = 1'b1; baud_div = 16'd53;
        tick_wait(4);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", tvalid); else passed++;
        checks++; if (tdata !== 8'h00) $display("FAIL reset_tdata: got %h expected 00", tdata); else passed++;
        checks++; if (tuser !== 4'h0) $display("FAIL reset_tuser: got %b expected 0000", tuser); else passed++;
        checks++; if (fifo_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
        checks++; if (tvalid_p !== 1'b0) $display("FAIL reset_tvalid_par: got %b expected 0", tvalid_p); else passed++;
    endtask

    task automatic test_basic();
        logic [11:0] e, o;
        baud_div = 16'd53;
        tick_wait(2);
        exp_q.push_back({4'b0000, 8'hA5});
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, -1);
        wait_obs(0, 1, 4 * bitc());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL basic_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL basic_beat: got %h expected %h", o, e); else passed++;
            end
        end
        tick_wait(bitc());
        checks++; if (obs_q.size() != 0) $display("FAIL basic_extra: got %0d extra beats expected 0", obs_q.size()); else passed++;
        checks++; if (fifo_count !== 5'd0) $display("FAIL basic_count: got %0d expected 0", fifo_count); else passed++;
        baud_div = 16'd3;
        tick_wait(200);
    endtask

    task automatic test_parity();
        logic [11:0] e, o;
        exp_p_q.push_back({4'b0001, 8'h3C});
        send_frame(1, 8'h3C, 1, 1'b1, 1'b1, -1);
        exp_p_q.push_back({4'b0000, 8'h3C});
        send_frame(1, 8'h3C, 1, 1'b0, 1'b1, -1);
        wait_obs(1, 2, 4 * bitc());
        while (exp_p_q.size() > 0) begin
            e = exp_p_q.pop_front();
            checks++;
            if (obs_p_q.size() == 0) $display("FAIL parity_beat: got no beat, expected %h", e);
            else begin
                o = obs_p_q.pop_front();
                if (o !== e) $display("FAIL parity_beat: got %h expected %h", o, e); else passed++;
            end
        end
    endtask

    task automatic test_frame_err();
        logic [11:0] e, o;
        exp_q.push_back({4'b0010, 8'h81});
        send_frame(0, 8'h81, 0, 1'b0, 1'b0, -1);
        wait_obs(0, 1, 4 * bitc());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL frame_err_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL frame_err_beat: got %h expected %h", o, e); else passed++;
            end
        end
        tick_wait(bitc());
    endtask

    task automatic test_break();
        logic [11:0] e, o;
        set_line(0, 1'b0);
        tick_wait(12 * bitc());
        checks++; if (obs_q.size() != 1) $display("FAIL break_count: got %0d beats expected 1", obs_q.size()); else passed++;
        exp_q.push_back({4'b0110, 8'h00});
        set_line(0, 1'b1);
        tick_wait(2 * bitc());
        exp_q.push_back({4'b0000, 8'h5A});
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, -1);
        wait_obs(0, 2, 4 * bitc());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL break_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL break_beat: got %h expected %h", o, e); else passed++;
            end
        end
    endtask

    task automatic test_overrun();
        logic [11:0] e, o;
        int base;
        base = ovr_cnt;
        tready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            send_frame(0, 8'(i), 0, 1'b0, 1'b1, -1);
        end
        tick_wait(4);
        checks++; if (fifo_count !== 5'd16) $display("FAIL overrun_count: got %0d expected 16", fifo_count); else passed++;
        checks++; if (ovr_cnt - base != 2) $display("FAIL overrun_pulses: got %0d expected 2", ovr_cnt - base); else passed++;
        checks++; if ({tvalid, tdata} !== 9'h100) $display("FAIL overrun_head_stall: got %b/%h expected 1/00", tvalid, tdata); else passed++;
        for (int i = 0; i < 16; i++) exp_q.push_back({4'b0000, 8'(i)});
        tready = 1'b1;
        wait_obs(0, 16, 200);
        exp_q.push_back({4'b1000, 8'h55});
        send_frame(0, 8'h55, 0, 1'b0, 1'b1, -1);
        exp_q.push_back({4'b0000, 8'h66});
        send_frame(0, 8'h66, 0, 1'b0, 1'b1, -1);
        wait_obs(0, 18, 4 * bitc());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL overrun_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL overrun_beat: got %h expected %h", o, e); else passed++;
            end
        end
    endtask

    task automatic test_noise();
        logic [11:0] e, o;
        set_line(0, 1'b0);
        tick_wait(3 * (int'(baud_div) + 1));
        set_line(0, 1'b1);
        tick_wait(3 * bitc());
        checks++; if (obs_q.size() != 0) $display("FAIL noise_false_start: got %0d beats expected 0", obs_q.size()); else passed++;
        checks++; if (tvalid !== 1'b0) $display("FAIL noise_tvalid: got %b expected 0", tvalid); else passed++;
        exp_q.push_back({4'b0000, 8'hF0});
        send_frame(0, 8'hF0, 0, 1'b0, 1'b1, 3);
        wait_obs(0, 1, 4 * bitc());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL glitch_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL glitch_beat: got %h expected %h", o, e); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e, o;
        int bc;
        bc = bitc();
        tready = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, -1);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, -1);
        send_frame(0, 8'h44, 0, 1'b0, 1'b1, -1);
        checks++; if (fifo_count !== 5'd3) $display("FAIL rst_mid_queued: got %0d expected 3", fifo_count); else passed++;
        set_line(0, 1'b0); tick_wait(bc);
        set_line(0, 1'b1); tick_wait(bc);
        set_line(0, 1'b0); tick_wait(bc / 2);
        aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b expected 0", tvalid); else passed++;
        checks++; if (fifo_count !== 5'd0) $display("FAIL rst_mid_count: got %0d expected 0", fifo_count); else passed++;
        checks++; if (tdata !== 8'h00) $display("FAIL rst_mid_tdata: got %h expected 00", tdata); else passed++;
        set_line(0, 1'b1);
        tready = 1'b1;
        tick_wait(2 * bc);
        checks++; if (obs_q.size() != 0) $display("FAIL rst_mid_leftover: got %0d beats expected 0", obs_q.size()); else passed++;
        exp_q.push_back({4'b0000, 8'h33});
        send_frame(0, 8'h33, 0, 1'b0, 1'b1, -1);
        wait_obs(0, 1, 4 * bc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) $display("FAIL rst_mid_beat: got no beat, expected %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL rst_mid_beat: got %h expected %h", o, e); else passed++;
            end
        end
        tick_wait(4);
        checks++; if (fifo_count !== 5'd0) $display("FAIL rst_mid_drained: got %0d expected 0", fifo_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_break();
        test_overrun();
        test_noise();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_fifo.md
Name: uart_rx_axis_fifo

Overview:
- Parametrised UART receiver. Runtime baud divisor, OVERSAMPLE-times oversampling with 3-sample majority vote, configurable word/parity/stop format.
- Break and overrun detection.
- Received words are buffered in an internal FIFO and drained over an AXI-Stream master with full tready backpressure.
- Sits between the board RX pin and the AXIS fabric. Replaces the fixed-rate, no-backpressure receiver.

Parameters:
- BIT_PER_WORD, 8, data bits per word, 5..9, LSB first.
- PARITY_BIT, 0, 0 none / 1 odd / 2 even.
- STOP_BITS_NUM, 1, 1 or 2.
- OVERSAMPLE, 16, ticks per bit, even, >=8.
- DIV_W, 16, width of baud_div.
- FIFO_DEPTH, 16, words, power of 2, >=2.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- baud_div  in  DIV_W  oversample tick every baud_div+1 aclk cycles.
- RX  in  1  asynchronous serial input, idle high.
- tdata  out  BIT_PER_WORD  received word.
- tuser  out  4  {overrun, break, frame_err, parity_err} for this word.
- tvalid  out  1  FIFO not empty.
- tready  in  1  sink accept.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words stored.
- overrun  out  1  one-cycle pulse per dropped word.

Behaviour:
- **Input sync:** RX passes through a 2-FF synchroniser, both stages reset to 1. All logic uses the synchronised value.
- **Tick generator:**
  - Counter 0..baud_div; tick on the cycle it equals baud_div, then wraps to 0.
  - Runs continuously out of reset.
  - baud_div is latched into the working divisor on START entry and held until return to IDLE.
- **FSM states:** IDLE, WAIT_HIGH, START, DATA, PARITY, STOP1, STOP2.
- **IDLE:**
  - On a tick with RX=0, go to START with lowcnt=1.
- **START:**
  - Each tick: RX=0 increments lowcnt; RX=1 is a false start, return to IDLE, no output.
  - At lowcnt==OVERSAMPLE/2 (start-bit centre): clear phase p to 0, go to DATA.
- **Bit sampling (DATA/PARITY/STOP):**
  - Phase p counts ticks 0..OVERSAMPLE-1 and wraps.
  - Each bit value = majority of samples at p=OVERSAMPLE-1, p=0 (wrap, bit centre) and p=1.
  - The bit is resolved on the p=1 tick.
- **DATA:** shift in BIT_PER_WORD bits, LSB first. After the last bit go to PARITY if PARITY_BIT!=0, else STOP1.
- **Parity:**
  - x = XOR(data bits, parity bit).
  - Odd: parity_err = ~x. Even: parity_err = x. None: 0.
- **STOP1/STOP2:**
  - Resolved stop bit 0 sets frame_err.
  - STOP2 is entered only when STOP_BITS_NUM==2.
- **Break:**
  - break = all data bits 0, parity bit 0 (if present), and every stop bit 0.
  - break implies frame_err=1.
- **Word completion:**
  - On the final stop-bit resolve tick, the word is pushed the same cycle.
  - FSM goes to IDLE, or to WAIT_HIGH if frame_err.
  - WAIT_HIGH returns to IDLE on the first tick with RX=1. No start detection while waiting.
- **FIFO:**
  - FIFO_DEPTH entries of {tuser, tdata}, show-ahead.
  - tvalid = !empty. tdata/tuser = head entry. Pop on tvalid&&tready.
  - Outputs are stable while tvalid&&!tready.
- **Full FIFO:**
  - Push while full with no pop: word dropped, overrun pulses for 1 cycle, sticky drop flag set.
  - Push while full with pop in the same cycle: accepted, count unchanged.
  - Sticky drop flag is written into tuser[3] of the next accepted word, then cleared.
- **fifo_count:** updates the cycle after push/pop. Push and pop together on a non-empty FIFO leave it unchanged.
- **Latency:** pushed word shows tvalid=1 on the next cycle.
- **Reset (any time, including mid-frame or mid-handshake):**
  - FSM to IDLE, FIFO emptied, sticky flag cleared.
  - Outputs the cycle after reset: tvalid=0, tdata=0, tuser=0, fifo_count=0, overrun=0.
  - A partial frame in flight is discarded.

Test Plan:
- **Basic 8N1 frame:** CLK 100 MHz, baud_div=53 (~115200 at x16), 8N1, tready=1, send 0xA5 -> exactly one beat, tdata=0xA5, tuser=4'b0000, fifo_count returns to 0.
- **Parity error:** PARITY_BIT=2, send 0x3C with parity bit 1 -> tdata=0x3C, tuser=4'b0001. With parity bit 0 -> tuser=4'b0000.
- **Frame error and break:**
  - Stop bit driven 0 on 0x81 -> tuser=4'b0010.
  - RX held low 12 bit times -> tdata=0x00, tuser=4'b0110. No further word until RX high; next 0x5A received cleanly.
- **Overrun:**
  - tready=0, send 18 words 0x00..0x11 -> fifo_count=16, overrun pulses twice.
  - tready=1 -> drains 0x00..0x0F in order.
  - Then send 0x55 -> tdata=0x55, tuser[3]=1. Following word has tuser[3]=0.
- **Noise immunity:**
  - RX low for 3 ticks then high -> no word.
  - Single-tick inverted glitch at p=0 of bit 3 of 0xF0 -> tdata=0xF0 (majority vote).
- **Reset mid-operation:**
  - aresetn low during DATA of a frame and while tvalid=1 with 3 words queued -> next cycle tvalid=0, fifo_count=0.
  - Next full frame 0x33 received correctly.
